// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central hazard sequencer for the 5-stage pipeline.
// It drives IF/ID stall/flush, PC write enable and ID/EX bubble insert for
// load-use hazards, taken-branch squashes and data-memory wait states.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic       branch_taken,
  input  logic       dmem_busy,
  output logic       stall_if_id,
  output logic       pc_write,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic [1:0] state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  // Counter reload values: cycles remaining after the entry cycle.
  localparam logic [2:0] LU_RELOAD = 3'(LU_STALL_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state_q, state_n;
  logic [2:0] cnt_q, cnt_n;
  logic       load_use;

  assign state = state_q;

  // A load in EX writes a register that the instruction in ID reads.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State and counter register; async reset returns to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Mealy next-state and outputs; priority is dmem_busy > branch > load-use.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    stall_if_id = 1'b0;
    pc_write    = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst) begin
      // Squash everything and keep the PC still until reset is released.
      pc_write    = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (dmem_busy) begin
      // Freeze: hold the front end; only RUN changes state so the wait is visible.
      stall_if_id = 1'b1;
      pc_write    = 1'b0;
      if (state_q == RUN) state_n = MEM_WAIT;
    end else if (branch_taken && (state_q != FLUSH)) begin
      // Taken branch from RUN, MEM_WAIT or LU_STALL (cancels any stall).
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        cnt_n   = FL_RELOAD;
      end else begin
        state_n = RUN;
      end
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          state_n = RUN;
          if (load_use) begin
            stall_if_id = 1'b1;
            pc_write    = 1'b0;
            flush_id_ex = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              state_n = LU_STALL;
              cnt_n   = LU_RELOAD;
            end
          end
        end
        LU_STALL: begin
          stall_if_id = 1'b1;
          pc_write    = 1'b0;
          flush_id_ex = 1'b1;
          cnt_n       = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_n = RUN;
        end
        FLUSH: begin
          // load_use is ignored here: the ID instruction is being squashed.
          flush_if_id = 1'b1;
          if (branch_taken) begin
            cnt_n = FL_RELOAD;
          end else begin
            cnt_n = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating event counters for stall and squash cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall_if_id) perf_stall_cnt <= sat_inc(perf_stall_cnt);
      if (flush_if_id) perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl built with
// LU_STALL_CYCLES=2 and FLUSH_CYCLES=3.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, dmem_busy;
  logic       stall_if_id, pc_write, flush_if_id, flush_id_ex;
  logic [1:0] state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Output bundle {stall_if_id, pc_write, flush_if_id, flush_id_ex}.
  logic [3:0] outs;
  assign outs = {stall_if_id, pc_write, flush_if_id, flush_id_ex};

  localparam logic [3:0] O_RUN   = 4'b0100;
  localparam logic [3:0] O_LU    = 4'b1001;
  localparam logic [3:0] O_BR    = 4'b0111;
  localparam logic [3:0] O_FL    = 4'b0110;
  localparam logic [3:0] O_FRZ   = 4'b1000;
  localparam logic [3:0] O_RST   = 4'b0011;

  hazard_ctrl #(.LU_STALL_CYCLES(2), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall_if_id(stall_if_id), .pc_write(pc_write),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .state(state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    total++; if (outs !== O_RST) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, O_RST); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    #3 rst = 1'b0;
    tick();
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL reset_release got=%b want=%b", outs, O_RUN); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_c1 got=%b want=%b", outs, O_LU); end
    tick();
    clear_inputs();
    #1;
    total++; if (outs !== O_LU || state !== 2'd1) begin bad++; $display("FAIL lu_c2 got=%b/%0d want=%b/1", outs, state, O_LU); end
    tick();
    total++; if (outs !== O_RUN || state !== 2'd0) begin bad++; $display("FAIL lu_done got=%b/%0d want=%b/0", outs, state, O_RUN); end
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1;
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_r0 got=%b want=%b", outs, O_RUN); end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use_rt();
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL lu_rt_unused got=%b want=%b", outs, O_RUN); end
    id_uses_rt = 1'b1;
    #1;
    total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rt_used got=%b want=%b", outs, O_LU); end
    tick();
    clear_inputs();
    tick();
    total++; if (outs !== O_RUN || state !== 2'd0) begin bad++; $display("FAIL lu_rt_done got=%b/%0d want=%b/0", outs, state, O_RUN); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    #1;
    total++; if (outs !== O_BR) begin bad++; $display("FAIL br_c1 got=%b want=%b", outs, O_BR); end
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (outs !== O_FL || state !== 2'd3) begin bad++; $display("FAIL br_c2 got=%b/%0d want=%b/3", outs, state, O_FL); end
    tick();
    total++; if (outs !== O_FL) begin bad++; $display("FAIL br_c3 got=%b want=%b", outs, O_FL); end
    tick();
    total++; if (outs !== O_RUN || state !== 2'd0) begin bad++; $display("FAIL br_done got=%b/%0d want=%b/0", outs, state, O_RUN); end
  endtask

  task automatic test_simultaneous();
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    #1;
    total++; if (outs !== O_BR) begin bad++; $display("FAIL sim_br_lu got=%b want=%b", outs, O_BR); end
    tick();
    clear_inputs();
    tick(); tick();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL sim_back_run got=%0d want=0", state); end
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    tick();
    clear_inputs();
    branch_taken = 1'b1;
    #1;
    total++; if (outs !== O_BR || state !== 2'd1) begin bad++; $display("FAIL sim_lu_branch got=%b/%0d want=%b/1", outs, state, O_BR); end
    tick();
    branch_taken = 1'b0;
    #1;
    total++; if (outs !== O_FL || state !== 2'd3) begin bad++; $display("FAIL sim_lu_to_flush got=%b/%0d want=%b/3", outs, state, O_FL); end
    tick(); tick();
    total++; if (outs !== O_RUN || state !== 2'd0) begin bad++; $display("FAIL sim_done got=%b/%0d want=%b/0", outs, state, O_RUN); end
  endtask

  task automatic test_mem_wait();
`ifdef HAZARD_PERF_EN
    logic [31:0] s0;
`endif
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    dmem_busy = 1'b1;
    #1;
`ifdef HAZARD_PERF_EN
    s0 = perf_stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      total++; if (outs !== O_FRZ || state !== 2'd3) begin bad++; $display("FAIL mw_freeze%0d got=%b/%0d want=%b/3", i, outs, state, O_FRZ); end
      tick();
    end
    dmem_busy = 1'b0;
    #1;
`ifdef HAZARD_PERF_EN
    total++; if (perf_stall_cnt !== s0 + 32'd4) begin bad++; $display("FAIL mw_perf got=%0d want=%0d", perf_stall_cnt, s0 + 32'd4); end
`endif
    total++; if (outs !== O_FL || state !== 2'd3) begin bad++; $display("FAIL mw_resume1 got=%b/%0d want=%b/3", outs, state, O_FL); end
    tick();
    total++; if (outs !== O_FL) begin bad++; $display("FAIL mw_resume2 got=%b want=%b", outs, O_FL); end
    tick();
    total++; if (outs !== O_RUN || state !== 2'd0) begin bad++; $display("FAIL mw_done got=%b/%0d want=%b/0", outs, state, O_RUN); end
    // Freeze from RUN parks in MEM_WAIT, which then behaves like RUN.
    dmem_busy = 1'b1;
    #1;
    total++; if (outs !== O_FRZ) begin bad++; $display("FAIL mw_run_freeze got=%b want=%b", outs, O_FRZ); end
    tick();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL mw_state got=%0d want=2", state); end
    dmem_busy = 1'b0; ex_mem_read = 1'b1; ex_rt = 5'd6; id_rs = 5'd6;
    #1;
    total++; if (outs !== O_LU) begin bad++; $display("FAIL mw_lu got=%b want=%b", outs, O_LU); end
    tick();
    clear_inputs();
    #1;
    total++; if (state !== 2'd1) begin bad++; $display("FAIL mw_to_lu got=%0d want=1", state); end
    tick();
  endtask

  task automatic test_async_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    tick();
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    total++; if (state !== 2'd0 || outs !== O_RST) begin bad++; $display("FAIL async_rst got=%b/%0d want=%b/0", outs, state, O_RST); end
    #2 rst = 1'b0;
    tick();
    total++; if (outs !== O_RUN) begin bad++; $display("FAIL async_release got=%b want=%b", outs, O_RUN); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_use_rt();
    test_branch();
    test_simultaneous();
    test_mem_wait();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
